// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Generates PC, IF/ID and ID/EX enables and bubbles for three cases:
//   - a load in EX whose result is needed by the instruction in ID (one bubble)
//   - data memory busy (whole front end frozen, nothing squashed)
//   - a taken branch (FLUSH_CYCLES cycles of IF/ID + ID/EX squash)
// The priority is: memory freeze first, then branch squash, then load-use stall.
// Outputs are Mealy (combinational from state and inputs) and are forced low
// while rst_ni is asserted.
// Optional feature macro: PERF_CNT_EN adds saturating stall/flush counters;
// without it both counter outputs are tied to zero and no counter flops exist.
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,   // legal 1..4
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [3:0]       id_rn_i,
    input  logic [3:0]       id_rm_i,
    input  logic             id_uses_rn_i,
    input  logic             id_uses_rm_i,
    input  logic [3:0]       ex_rd_i,
    input  logic             ex_reg_write_i,
    input  logic             ex_mem_to_reg_i,
    input  logic             branch_taken_i,
    input  logic             mem_busy_i,
    output logic             pc_enable_o,
    output logic             if_id_enable_o,
    output logic             if_id_flush_o,
    output logic             id_ex_enable_o,
    output logic             id_ex_flush_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_cycles_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    // Remaining squash cycles after the branch cycle itself.
    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

    state_e     state_q, state_d;
    logic [1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic flush_mode;
    logic pc_en, if_id_en, if_id_fl, id_ex_en, id_ex_fl;

    // r15 is the PC and is never a forwarding/hazard target.
    assign load_use = ex_mem_to_reg_i & ex_reg_write_i & (ex_rd_i != 4'd15) &
                      ((id_uses_rn_i & (id_rn_i == ex_rd_i)) |
                       (id_uses_rm_i & (id_rm_i == ex_rd_i)));

    // A squash is pending either in FLUSH, or in MEM_WAIT entered from FLUSH
    // (flush_cnt is held through the freeze, so nonzero means squash pending).
    assign flush_mode = (state_q == FLUSH) ||
                        ((state_q == MEM_WAIT) && (flush_cnt_q != 2'd0));

    // Next-state and Mealy output decode, in priority order.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_fl    = 1'b0;
        id_ex_en    = 1'b0;
        id_ex_fl    = 1'b0;
        if (mem_busy_i) begin
            // Freeze everything; a branch in EX will be re-presented later.
            state_d = MEM_WAIT;
        end else if (branch_taken_i || flush_mode) begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
            if_id_fl = 1'b1;
            id_ex_en = 1'b1;
            id_ex_fl = 1'b1;
            if (branch_taken_i) begin
                flush_cnt_d = FLUSH_RELOAD;
                state_d     = MULTI_FLUSH ? FLUSH : RUN;
            end else begin
                flush_cnt_d = flush_cnt_q - 2'd1;
                state_d     = (flush_cnt_q == 2'd1) ? RUN : FLUSH;
            end
        end else if (load_use) begin
            // Hold PC and IF/ID one cycle, bubble into EX; forwarding covers the rest.
            id_ex_en = 1'b1;
            id_ex_fl = 1'b1;
            state_d  = RUN;
        end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
            id_ex_en = 1'b1;
            state_d  = RUN;
        end
    end

    // Sequencer state and remaining-squash count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            flush_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Reset gates every control output low immediately.
    assign pc_enable_o    = rst_ni & pc_en;
    assign if_id_enable_o = rst_ni & if_id_en;
    assign if_id_flush_o  = rst_ni & if_id_fl;
    assign id_ex_enable_o = rst_ni & id_ex_en;
    assign id_ex_flush_o  = rst_ni & id_ex_fl;

`ifdef PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] flush_cycles_q;
    logic             stall_evt;

    // A load-use bubble is the only case with ID/EX flushed but IF/ID not.
    assign stall_evt = id_ex_flush_o & ~if_id_flush_o;

    // Saturating performance counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cycles_q <= '0;
            flush_cycles_q <= '0;
        end else begin
            if (stall_evt && (stall_cycles_q != '1))
                stall_cycles_q <= stall_cycles_q + CNT_ONE;
            if (if_id_flush_o && (flush_cycles_q != '1))
                flush_cycles_q <= flush_cycles_q + CNT_ONE;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_cycles_o = flush_cycles_q;
`else
    assign stall_cycles_o = '0;
    assign flush_cycles_o = '0;
`endif

endmodule
